demux_1_8: RTL and testbench
============================

Name: demux_1_8

Overview:
- Registered 1-to-8 demultiplexer: routes data input D to one of eight outputs Y1..Y8 selected by the 3-bit select {a,b,c}.
- All non-selected outputs are driven to zero.
- Outputs are registered on the system clock, so the block can sit directly on a synchronous datapath as a fan-out/steering stage.

Parameters:
- WIDTH, 1, bit width of D and of each output Y1..Y8.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  1  select bit 2 (MSB).
- b  input  1  select bit 1.
- c  input  1  select bit 0 (LSB).
- D  input  WIDTH  data to be steered.
- Y1  output  WIDTH  output for select 3'b000.
- Y2  output  WIDTH  output for select 3'b001.
- Y3  output  WIDTH  output for select 3'b010.
- Y4  output  WIDTH  output for select 3'b011.
- Y5  output  WIDTH  output for select 3'b100.
- Y6  output  WIDTH  output for select 3'b101.
- Y7  output  WIDTH  output for select 3'b110.
- Y8  output  WIDTH  output for select 3'b111.

Behaviour:
- Select index s = {a,b,c}, a is MSB, range 0..7.
- Next-state function:
  - Y(s+1) <= D.
  - Every other Yk <= 0 (all WIDTH bits).
- Outputs are registers driven directly by flops, with no combinational path from inputs to outputs.
- Latency is exactly one clock: inputs sampled on rising edge N appear on the outputs after edge N and hold until edge N+1.
- Reset:
  - rst_n low immediately (asynchronously) forces Y1..Y8 to 0, independent of clk.
  - Outputs stay 0 while rst_n is low.
  - On the first rising clk edge after rst_n deasserts, inputs are sampled normally.
  - Deassertion is expected to be synchronised externally.
- Reset mid-operation: any previously routed value is cleared at once; no history is retained.
- D = 0 with any select: all outputs 0 after the edge, indistinguishable from an idle state. This is intentional.
- Select change between edges: only the value present at the rising edge matters. Intermediate glitches on a/b/c/D have no effect.
- At most one output is nonzero at any time (one-hot-or-zero across Y1..Y8, per bit).
- X/Z on select inputs is not a supported use. Implementation may propagate X; verification does not check it.
- No internal state other than the eight output registers.

Test Plan:
- Reset: drive rst_n=0 with a=b=c=0, D=1 and the clock running -> Y1..Y8 all 0 immediately and on every edge while rst_n=0. Release rst_n -> next edge gives Y1=1, others 0.
- Exhaustive sweep (WIDTH=1): for s=0..7 and D in {0,1}, apply inputs, clock once -> Y(s+1)=D and all other outputs 0. Check all 16 combinations, e.g. a=1,b=0,c=1,D=1 -> Y6=1, rest 0.
- Latency: change select from 3'b000 to 3'b111 with D=1 mid-cycle -> outputs unchanged until the next rising edge, then Y1=0 and Y8=1.
- Async reset mid-operation: with Y4=1 (a=0,b=1,c=1,D=1), pulse rst_n low between clock edges -> Y4 drops to 0 without a clock edge. After release and one edge, Y4=1 again.
- Wide data (WIDTH=8): D=8'hA5, select 3'b010 -> Y3=8'hA5, others 8'h00. Then D=8'h3C, select 3'b110 -> Y7=8'h3C, Y3=8'h00.
- Invariant check over random stimulus (≥1000 cycles): at most one Yk nonzero per cycle, and it equals D sampled at the previous edge.

Source files
------------

// File: rtl/demux_1_8.sv
// Registered 1-to-8 demultiplexer: D is steered to the output selected by {a,b,c}
// one clock after sampling; every other output is cleared on the same edge.
module demux_1_8 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic [WIDTH-1:0] Y4,
  output logic [WIDTH-1:0] Y5,
  output logic [WIDTH-1:0] Y6,
  output logic [WIDTH-1:0] Y7,
  output logic [WIDTH-1:0] Y8
);

  logic [2:0]       sel;
  logic [WIDTH-1:0] y_d [8];
  logic [WIDTH-1:0] y_q [8];

  assign sel = {a, b, c};

  // One lane per output; only the selected lane loads D, the rest load zero.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign y_d[gi] = (sel == 3'(gi)) ? D : '0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        y_q[gi] <= '0;
      end else begin
        y_q[gi] <= y_d[gi];
      end
    end
  end

  assign Y1 = y_q[0];
  assign Y2 = y_q[1];
  assign Y3 = y_q[2];
  assign Y4 = y_q[3];
  assign Y5 = y_q[4];
  assign Y6 = y_q[5];
  assign Y7 = y_q[6];
  assign Y8 = y_q[7];

endmodule

// File: tb/tb_demux_1_8.sv
// Bench for demux_1_8: a 1-bit and an 8-bit instance share clock, reset and select,
// checked against a shift-based reference model of the routed output vector.
module tb_demux_1_8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a, b, c;
  logic [0:0] d1;
  logic [7:0] d8;
  logic [0:0] n1 [8];
  logic [7:0] n8 [8];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  demux_1_8 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .D(d1),
    .Y1(n1[0]), .Y2(n1[1]), .Y3(n1[2]), .Y4(n1[3]),
    .Y5(n1[4]), .Y6(n1[5]), .Y7(n1[6]), .Y8(n1[7])
  );

  demux_1_8 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .D(d8),
    .Y1(n8[0]), .Y2(n8[1]), .Y3(n8[2]), .Y4(n8[3]),
    .Y5(n8[4]), .Y6(n8[5]), .Y7(n8[6]), .Y8(n8[7])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] got1();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = n1[k][0];
    return v;
  endfunction

  function automatic logic [63:0] got8();
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = n8[k];
    return v;
  endfunction

  function automatic int nonzero8();
    int n = 0;
    for (int k = 0; k < 8; k++) if (n8[k] != 8'h00) n++;
    return n;
  endfunction

  // Reference: the concatenated outputs {Y8..Y1} equal D shifted into lane s.
  function automatic logic [7:0] model1(input int s, input logic [0:0] d);
    return 8'(d) << s;
  endfunction

  function automatic logic [63:0] model8(input int s, input logic [7:0] d);
    return 64'(d) << (8 * s);
  endfunction

  task automatic drive(input int s, input logic [0:0] dv1, input logic [7:0] dv8);
    {a, b, c} = 3'(s);
    d1 = dv1;
    d8 = dv8;
  endtask

  // Drive, clock once, then compare both instances against the model.
  task automatic apply(input string tag, input int s, input logic [0:0] dv1, input logic [7:0] dv8);
    drive(s, dv1, dv8);
    @(posedge clk);
    #1;
    check({tag, "_w1"}, 64'(got1()), 64'(model1(s, dv1)));
    check({tag, "_w8"}, got8(), model8(s, dv8));
    check({tag, "_onehot"}, 64'(nonzero8() <= 1), 64'd1);
    $display("txn %s s=%0d d1=%0d d8=%h y1=%b y8=%h", tag, s, dv1, dv8, got1(), got8());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b1, 8'hFF);

    // Reset holds all outputs at zero while the clock runs.
    #1;
    check("rst_imm_w1", 64'(got1()), 64'd0);
    check("rst_imm_w8", got8(), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold_w1", 64'(got1()), 64'd0);
      check("rst_hold_w8", got8(), 64'd0);
      $display("txn rst_hold edge=%0d y1=%b y8=%h", i, got1(), got8());
    end
    rst_n = 1'b1;
    apply("rst_release", 0, 1'b1, 8'hFF);

    // Exhaustive select x D sweep.
    for (int s = 0; s < 8; s++) begin
      for (int d = 0; d < 2; d++) begin
        apply("sweep", s, 1'(d), d ? 8'h5A : 8'h00);
      end
    end

    // Mid-cycle select change is invisible until the next edge.
    apply("lat_pre", 0, 1'b1, 8'h11);
    #2;
    drive(7, 1'b1, 8'h22);
    #3;
    check("lat_hold_w1", 64'(got1()), 64'h01);
    check("lat_hold_w8", got8(), 64'h11);
    $display("txn lat_hold y1=%b y8=%h", got1(), got8());
    @(posedge clk);
    #1;
    check("lat_post_w1", 64'(got1()), 64'h80);
    check("lat_post_w8", got8(), model8(7, 8'h22));
    $display("txn lat_post y1=%b y8=%h", got1(), got8());

    // Asynchronous reset pulse between edges clears outputs without a clock.
    apply("async_pre", 3, 1'b1, 8'hC3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clr_w1", 64'(got1()), 64'd0);
    check("async_clr_w8", got8(), 64'd0);
    $display("txn async_clr y1=%b y8=%h", got1(), got8());
    #1;
    rst_n = 1'b1;
    apply("async_post", 3, 1'b1, 8'hC3);

    // Wide-data directed cases.
    apply("wide_a5", 2, 1'b1, 8'hA5);
    apply("wide_3c", 6, 1'b0, 8'h3C);

    // Random stimulus.
    for (int i = 0; i < 1000; i++) begin
      apply("rand", int'($urandom_range(0, 7)), 1'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
